// File: rtl/job_dispatcher.sv
// Job dispatcher: a request FIFO feeding a launch/monitor FSM that drives a downstream
// worker through start/busy, with per-job timeout abort and a completed-job counter.
module job_dispatcher #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [DATA_W-1:0]        req_data,
    output logic                     req_ready,
    output logic                     start,
    output logic [DATA_W-1:0]        job_data,
    input  logic                     busy,
    output logic                     done_pulse,
    output logic                     timeout_err,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [15:0]              jobs_done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_RUN
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W:0]      r_count;
    logic [CNT_W-1:0]    r_tmo_cnt;
    logic                r_start;
    logic                r_done;
    logic                r_err;
    logic [DATA_W-1:0]   r_job_data;
    logic [15:0]         r_jobs_done;

    logic                w_push;
    logic                w_pop;
    logic                w_tmo_hit;

    assign req_ready   = (r_count < FULL_CNT);
    assign w_push      = req_valid && req_ready;
    assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
    // Abort on the edge that closes the TIMEOUT-th cycle spent waiting.
    assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);

    assign start       = r_start;
    assign done_pulse  = r_done;
    assign timeout_err = r_err;
    assign job_data    = r_job_data;
    assign fifo_count  = r_count;
    assign jobs_done   = r_jobs_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_tmo_cnt   <= '0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_job_data  <= '0;
            r_jobs_done <= '0;
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_job_data <= r_mem[r_rd_ptr];
                        r_rd_ptr   <= r_rd_ptr + 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_start   <= 1'b1;
                    r_tmo_cnt <= '0;
                    r_state   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (busy) begin
                        r_tmo_cnt <= '0;
                        r_state   <= S_RUN;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!busy) begin
                        r_done      <= 1'b1;
                        r_jobs_done <= r_jobs_done + 1'b1;
                        r_state     <= S_IDLE;
                    end else if (w_tmo_hit) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_job_dispatcher.sv
// Self-checking bench for job_dispatcher: a queue-based job model checked every cycle,
// a simple worker responder, and directed scenarios with hand-computed expectations.
module tb_job_dispatcher;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic [DATA_W-1:0] req_data;
    logic              req_ready;
    logic              start;
    logic [DATA_W-1:0] job_data;
    logic              busy = 1'b0;
    logic              done_pulse;
    logic              timeout_err;
    logic [CW-1:0]     fifo_count;
    logic [15:0]       jobs_done;

    job_dispatcher #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .start      (start),
        .job_data   (job_data),
        .busy       (busy),
        .done_pulse (done_pulse),
        .timeout_err(timeout_err),
        .fifo_count (fifo_count),
        .jobs_done  (jobs_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Job-level model: a payload queue plus the lifecycle of the single job in flight.
    // Phase 0 = no job, 1 = just taken from the queue, 2 = awaiting busy, 3 = worker running.
    logic [DATA_W-1:0] m_q[$];
    int                m_phase = 0;
    int                m_waited = 0;
    int                m_jobs = 0;
    bit                m_start = 0;
    bit                m_done = 0;
    bit                m_err = 0;
    bit                m_init = 0;
    bit                m_push;
    logic [DATA_W-1:0] m_job = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_q.delete();
            m_phase = 0; m_waited = 0; m_jobs = 0;
            m_start = 0; m_done = 0; m_err = 0; m_job = '0;
            m_init = 1;
        end else begin
            m_push  = req_valid && (m_q.size() < DEPTH);
            m_start = 0;
            m_done  = 0;
            case (m_phase)
                0: if (m_q.size() > 0) begin m_job = m_q.pop_front(); m_phase = 1; end
                1: begin m_start = 1; m_waited = 0; m_phase = 2; end
                2: if (busy) begin
                       m_phase = 3; m_waited = 0;
                   end else begin
                       m_waited++;
                       if (m_waited == TIMEOUT) begin m_err = 1; m_phase = 0; end
                   end
                default: if (!busy) begin
                       m_done = 1; m_jobs = (m_jobs + 1) % 65536; m_phase = 0;
                   end else begin
                       m_waited++;
                       if (m_waited == TIMEOUT) begin m_err = 1; m_phase = 0; end
                   end
            endcase
            if (m_push) m_q.push_back(req_data);
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("start", int'(start), int'(m_start));
            chk("done_pulse", int'(done_pulse), int'(m_done));
            chk("timeout_err", int'(timeout_err), int'(m_err));
            chk("job_data", int'(job_data), int'(m_job));
            chk("fifo_count", int'(fifo_count), m_q.size());
            chk("req_ready", int'(req_ready), int'(m_q.size() < DEPTH));
            chk("jobs_done", int'(jobs_done), m_jobs);
        end
    end

    // Observation log used by the directed scenarios.
    logic [DATA_W-1:0] start_log[$];
    int n_done = 0;
    int start_cyc = 0;
    int err_cyc = 0;
    bit err_seen = 0;

    always @(negedge clk) begin
        if (start) begin start_log.push_back(job_data); start_cyc = cyc; end
        if (done_pulse) n_done++;
        if (timeout_err && !err_seen) begin err_seen = 1; err_cyc = cyc; end
    end

    // Worker: raises busy one cycle after seeing start and holds it wk_len cycles.
    bit wk_en = 1;
    int wk_len = 3;
    int wk_wait = 0;
    int wk_hold = 0;

    always @(negedge clk) begin
        if (rst) begin
            busy = 1'b0; wk_wait = 0; wk_hold = 0;
        end else if (wk_wait > 0) begin
            wk_wait--;
            if (wk_wait == 0) begin busy = 1'b1; wk_hold = wk_len; end
        end else if (wk_hold > 0) begin
            wk_hold--;
            if (wk_hold == 0) busy = 1'b0;
        end else if (wk_en && start) begin
            wk_wait = 1;
        end
    end

    function automatic int log_at(input int idx);
        return (idx < start_log.size()) ? int'(start_log[idx]) : -1;
    endfunction

    initial begin
        int push_cyc;
        int acc;
        int s_first;
        int jd_before;
        bit got;

        rst = 1'b1; req_valid = 1'b0; req_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_fifo_count", int'(fifo_count), 0);
        chk("reset_jobs_done", int'(jobs_done), 0);
        chk("reset_start", int'(start), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", int'(req_ready), 1);

        // Single job 0xA5 with a 3-cycle worker.
        start_log.delete(); n_done = 0;
        req_valid = 1'b1; req_data = 8'hA5;
        @(negedge clk);
        req_valid = 1'b0; push_cyc = cyc;
        repeat (15) @(negedge clk);
        chk("single_starts", start_log.size(), 1);
        chk("single_job_data", log_at(0), 'hA5);
        chk("single_latency", start_cyc - push_cyc, 2);
        chk("single_dones", n_done, 1);
        chk("single_jobs_done", int'(jobs_done), 1);

        // Ordering with a toggling worker.
        start_log.delete(); n_done = 0; wk_len = 1;
        for (int i = 1; i <= 3; i++) begin
            req_valid = 1'b1; req_data = 8'(i);
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (30) @(negedge clk);
        chk("order_starts", start_log.size(), 3);
        chk("order_job0", log_at(0), 'h01);
        chk("order_job1", log_at(1), 'h02);
        chk("order_job2", log_at(2), 'h03);
        chk("order_dones", n_done, 3);
        chk("order_jobs_done", int'(jobs_done), 4);

        // Push coinciding with pop at fifo_count == 2.
        start_log.delete(); wk_len = 4;
        req_valid = 1'b1; req_data = 8'h21; @(negedge clk);
        req_data = 8'h22; @(negedge clk);
        req_data = 8'h23; @(negedge clk);
        req_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done_pulse) got = 1;
        end
        chk("samecyc_done_seen", int'(got), 1);
        chk("samecyc_count_before", int'(fifo_count), 2);
        req_valid = 1'b1; req_data = 8'h24;
        @(negedge clk);
        req_valid = 1'b0;
        chk("samecyc_count_after", int'(fifo_count), 2);
        repeat (60) @(negedge clk);
        chk("samecyc_job3", log_at(3), 'h24);
        chk("samecyc_jobs_done", int'(jobs_done), 8);

        // Fill while a job waits on a silent worker, then timeout.
        wk_en = 0; start_log.delete(); err_seen = 0;
        req_valid = 1'b1; req_data = 8'h30; @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        s_first = start_cyc;
        acc = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            req_valid = 1'b1; req_data = 8'(8'h40 + i);
            if (req_ready) acc++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("fill_accepted", acc, DEPTH);
        chk("fill_count", int'(fifo_count), DEPTH);
        chk("fill_ready_low", int'(req_ready), 0);
        jd_before = int'(jobs_done);
        for (int i = 0; i < TIMEOUT + 10 && !err_seen; i++) @(negedge clk);
        chk("tmo_err_seen", int'(err_seen), 1);
        chk("tmo_cycles", err_cyc - s_first, TIMEOUT);
        repeat (4) @(negedge clk);
        chk("tmo_next_job", log_at(1), 'h40);
        chk("tmo_jobs_done", int'(jobs_done), jd_before);
        repeat (100) @(negedge clk);
        chk("tmo_all_starts", start_log.size(), 5);
        chk("tmo_last_job", log_at(4), 'h43);
        chk("tmo_jobs_done_end", int'(jobs_done), 8);

        // Reset while running with two jobs queued.
        wk_en = 1; wk_len = 20;
        req_valid = 1'b1; req_data = 8'h50; @(negedge clk);
        req_data = 8'h51; @(negedge clk);
        req_data = 8'h52; @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_busy_before", int'(busy), 1);
        chk("rst_count_before", int'(fifo_count), 2);
        n_done = 0; start_log.delete();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_count_after", int'(fifo_count), 0);
        chk("rst_err_cleared", int'(timeout_err), 0);
        chk("rst_jobs_cleared", int'(jobs_done), 0);
        repeat (20) @(negedge clk);
        chk("rst_no_done", n_done, 0);
        chk("rst_no_start", start_log.size(), 0);
        req_valid = 1'b1; req_data = 8'h66; @(negedge clk);
        req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_new_job", log_at(0), 'h66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, required end before 200000");
        $fatal(1, "watchdog");
    end
endmodule
